// File: rtl/mul_div_controller_if.sv
// mul_div_controller_if
//   Bundles the request, move-to and result signals of the HI/LO multiply/divide
//   unit. Clock and reset stay outside the interface.
//
//   Handshake: start is a single-cycle request sampled on the rising edge.
//   The unit accepts it whenever busy is low (IDLE or DONE). A start seen while
//   busy is high is dropped: it is not queued and it is not flagged. There is no
//   ready signal. Completion is signalled by a one-cycle done pulse, and hi/lo
//   are already valid in that cycle.
//
//   master : requester (drives start/op/a/b/hiwrite/lowrite/wrdata)
//   slave  : the controller (drives busy/done/divbyzero/hi/lo/state)
//   state  : FSM state, exposed for debug only

interface mul_div_controller_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hiwrite;
  logic        lowrite;
  logic [31:0] wrdata;
  logic        busy;
  logic        done;
  logic        divbyzero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state;

  modport master (
    output start, op, a, b, hiwrite, lowrite, wrdata,
    input  busy, done, divbyzero, hi, lo, state
  );

  modport slave (
    input  start, op, a, b, hiwrite, lowrite, wrdata,
    output busy, done, divbyzero, hi, lo, state
  );
endinterface

// File: rtl/mul_div_controller.sv
// mul_div_controller
//   Iterative 32x32 multiply/divide unit with architectural HI/LO registers.
//   op: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
//   A multiply leaves product[63:32] in HI and product[31:0] in LO.
//   A divide leaves the remainder in HI and the quotient in LO.
//
//   Ports
//     clk   : single clock; all state updates on the rising edge
//     reset : synchronous, active-high
//     bus   : mul_div_controller_if.slave (request, move-to and result signals)
//
//   Timing: a start sampled at edge k gives 32 iteration steps at edges
//   k+1..k+32. A sign-fixup/write-back edge at k+33 updates HI/LO, and done is
//   high for the cycle that follows.
//
//   Optional feature: define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a
//   single-cycle product. HI/LO then update at edge k+1. Divide is unchanged.

module mul_div_controller (
  input  logic                 clk,
  input  logic                 reset,
  mul_div_controller_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  // Multiply: {partial product high, remaining multiplier bits / product low}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
  logic [63:0] pr;
  // Multiply: multiplicand magnitude. Divide: divisor magnitude.
  logic [31:0] mc;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        dbz_q;

  // Operand magnitudes at issue. The iteration always runs unsigned, and the
  // signs are reapplied at write-back.
  logic        issue_sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    issue_sgn = ~bus.op[0];
    a_mag     = (issue_sgn && bus.a[31]) ? 32'd0 - bus.a : bus.a;
    b_mag     = (issue_sgn && bus.b[31]) ? 32'd0 - bus.b : bus.b;
  end

  logic run_sgn;
  logic run_mul;
  assign run_sgn = ~op_q[0];
  assign run_mul = ~op_q[1];

  // One radix-2 step.
  // Multiply: conditional add into the upper half, then shift right.
  // Divide: shift left and compare. When the shifted partial remainder is at
  // least the divisor, the 32-bit difference is exact and fits.
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [31:0] div_diff;
  logic [63:0] step_pr;

  always_comb begin
    mul_sum  = {1'b0, pr[63:32]} + (pr[0] ? {1'b0, mc} : 33'd0);
    rem_sh   = pr[63:31];
    div_diff = pr[62:31] - mc;
    if (run_mul) begin
      step_pr = {mul_sum, pr[31:1]};
    end else if (rem_sh >= {1'b0, mc}) begin
      step_pr = {div_diff, pr[30:0], 1'b1};
    end else begin
      step_pr = {pr[62:0], 1'b0};
    end
  end

  logic [63:0] mul_res;
  logic        fast_fin;

`ifdef MULDIV_FAST_MUL_EN
  // Sign extension is gated by run_sgn, so a single truncated 64-bit product
  // serves both MULT and MULTU.
  assign fast_fin = run_mul;
  assign mul_res  = {{32{opa_q[31] & run_sgn}}, opa_q} *
                    {{32{opb_q[31] & run_sgn}}, opb_q};
`else
  assign fast_fin = 1'b0;
  assign mul_res  = (run_sgn && (opa_q[31] ^ opb_q[31])) ? 64'd0 - pr : pr;
`endif

  // Signed divide truncates toward zero, and the remainder follows the
  // dividend's sign. 0x80000000 / -1 comes out as 0x80000000 remainder 0
  // without any special case.
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    quot = (run_sgn && (opa_q[31] ^ opb_q[31])) ? 32'd0 - pr[31:0] : pr[31:0];
    rem  = (run_sgn && opa_q[31]) ? 32'd0 - pr[63:32] : pr[63:32];
  end

  logic finish;
  assign finish = (state == RUN) && ((cnt == 6'd32) || fast_fin);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 6'd0;
      op_q  <= 2'd0;
      opa_q <= 32'd0;
      opb_q <= 32'd0;
      pr    <= 64'd0;
      mc    <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // Move-to writes and a new start may share an edge. The operation's
          // result overwrites the written value later.
          if (bus.hiwrite) hi_q <= bus.wrdata;
          if (bus.lowrite) lo_q <= bus.wrdata;
          if (bus.start) begin
            state <= RUN;
            cnt   <= 6'd0;
            op_q  <= bus.op;
            opa_q <= bus.a;
            opb_q <= bus.b;
            if (!bus.op[1]) begin
              pr <= {32'd0, b_mag};
              mc <= a_mag;
            end else begin
              pr <= {32'd0, a_mag};
              mc <= b_mag;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (finish) begin
            state <= DONE;
            if (run_mul) begin
              hi_q <= mul_res[63:32];
              lo_q <= mul_res[31:0];
            end else if (opb_q == 32'd0) begin
              dbz_q <= 1'b1;
            end else begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            pr  <= step_pr;
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.divbyzero = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_mul_div_controller.sv
// tb_mul_div_controller
//   Directed scenarios plus a randomized phase for mul_div_controller.
//   A behavioural model predicts busy/done/divbyzero/hi/lo every cycle. It uses
//   a completion countdown and plain 64-bit arithmetic, and keeps the pending
//   results in exp_q. Directed scenarios also compare against hand-computed
//   literals.

module tb_mul_div_controller;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_div_controller_if bus ();

  mul_div_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- counters / check ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Result format: {divbyzero, hi, lo}
  function automatic logic [64:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    p = 64'd0;
    q = 32'd0;
    r = 32'd0;
    case (op)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: if (b != 32'd0) begin q = 32'(sa / sb); r = 32'(sa % sb); end
      default: if (b != 32'd0) begin q = a / b; r = a % b; end
    endcase
    if (op[1]) return {(b == 32'd0), r, q};
    return {1'b0, p};
  endfunction

  function automatic int latency(input logic [1:0] op);
    return op[1] ? DIV_LAT : MUL_LAT;
  endfunction

  logic [64:0] exp_q[$];
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_dbz  = 1'b0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;

  always @(posedge clk) begin : model
    logic [64:0] r;
    if (reset) begin
      m_left = 0;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left--;
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_left == 0) begin
        r = exp_q.pop_front();
        m_done = 1'b1;
        m_dbz  = r[64];
        if (!r[64]) begin
          m_hi = r[63:32];
          m_lo = r[31:0];
        end
      end
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (bus.hiwrite) m_hi = bus.wrdata;
      if (bus.lowrite) m_lo = bus.wrdata;
      if (bus.start) begin
        exp_q.push_back(ref_result(bus.op, bus.a, bus.b));
        m_left = latency(bus.op);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(bus.busy), 64'(m_left > 0));
      check("done", 64'(bus.done), 64'(m_done));
      check("divbyzero", 64'(bus.divbyzero), 64'(m_dbz));
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.op      = 2'd0;
    bus.a       = 32'd0;
    bus.b       = 32'd0;
    bus.hiwrite = 1'b0;
    bus.lowrite = 1'b0;
    bus.wrdata  = 32'd0;
  endtask

  // Start is sampled at the edge following the call. The task returns just
  // after that edge with the operands scrambled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // lat = edges from the start edge to the edge that raised done.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i - 1;
        break;
      end
    end
    if (lat < 0) begin
      n_total++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int ndone;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_dbz", 64'(bus.divbyzero), 64'd0);

    // MULT -2 * 3
    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(40, lat);
    check("mult_lat", 64'(lat), 64'(MUL_LAT));
    check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

    // MULTU max * max
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(40, lat);
    check("multu_lat", 64'(lat), 64'(MUL_LAT));
    check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(bus.lo), 64'h0000_0001);

    // DIV -7 / 2, then DIVU 7 / 0
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(40, lat);
    check("div_lat", 64'(lat), 64'(DIV_LAT));
    check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    issue(2'd3, 32'd7, 32'd0);
    wait_done(40, lat);
    check("dbz_lat", 64'(lat), 64'(DIV_LAT));
    check("dbz_flag", 64'(bus.divbyzero), 64'd1);
    check("dbz_hi_kept", 64'(bus.hi), 64'hFFFF_FFFF);
    check("dbz_lo_kept", 64'(bus.lo), 64'hFFFF_FFFD);

    // Signed overflow
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(40, lat);
    check("ovf_lo", 64'(bus.lo), 64'h8000_0000);
    check("ovf_hi", 64'(bus.hi), 64'd0);

    // Start and HiWrite mid-RUN are ignored
    issue(2'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.op      = 2'd1;
    bus.a       = 32'd55;
    bus.b       = 32'd66;
    bus.hiwrite = 1'b1;
    bus.wrdata  = 32'h1234;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.hiwrite = 1'b0;
    wait_done(40, lat);
    check("midrun_lo", 64'(bus.lo), 64'd14);
    check("midrun_hi", 64'(bus.hi), 64'd2);
    @(negedge clk);
    check("midrun_idle", 64'(bus.busy), 64'd0);

    // Reset during iteration aborts the operation
    issue(2'd3, 32'hDEAD_BEEF, 32'd13);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    issue(2'd0, 32'd7, 32'hFFFF_FFFD);
    wait_done(40, lat);
    check("after_abort_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("after_abort_lo", 64'(bus.lo), 64'hFFFF_FFEB);

    // Back-to-back start in DONE together with LoWrite
    issue(2'd3, 32'd1000, 32'd3);
    wait_done(40, lat);
    check("b2b_first_lo", 64'(bus.lo), 64'd333);
    check("b2b_first_hi", 64'(bus.hi), 64'd1);
    bus.start   = 1'b1;
    bus.op      = 2'd3;
    bus.a       = 32'd50;
    bus.b       = 32'd7;
    bus.lowrite = 1'b1;
    bus.wrdata  = 32'hAAAA;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.lowrite = 1'b0;
    @(negedge clk);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    check("b2b_lo_written", 64'(bus.lo), 64'hAAAA);
    repeat (15) @(negedge clk);
    check("b2b_lo_held", 64'(bus.lo), 64'hAAAA);
    issue_wait_b2b: begin
      // 16 negedges have already passed since the start edge.
      wait_done(40, lat);
      check("b2b_lat", 64'(lat + 16), 64'(DIV_LAT));
      check("b2b_second_lo", 64'(bus.lo), 64'd7);
      check("b2b_second_hi", 64'(bus.hi), 64'd1);
    end

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.op      = 2'($urandom_range(0, 3));
      bus.a       = rand_operand();
      bus.b       = rand_operand();
      bus.hiwrite = ($urandom_range(0, 7) == 0);
      bus.lowrite = ($urandom_range(0, 7) == 0);
      bus.wrdata  = $urandom;
      reset       = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("final_idle", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
